// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: NUM_PORTS requesters share NUM_BANKS single-port SRAM banks.
// Each bank runs its own round-robin arbiter. Read data is steered back to the
// requesting port through a per-bank {valid, port id} tag pipeline that is
// READ_LAT deep.
module sram_bank_arbiter #(
    parameter  int NUM_PORTS = 4,
    parameter  int NUM_BANKS = 8,
    parameter  int ADDR_W    = 16,
    parameter  int WDATA_W   = 8,
    parameter  int RDATA_W   = 32,
    parameter  int READ_LAT  = 1,
    parameter  int CNT_W     = 32,
    localparam int BANK_W    = $clog2(NUM_BANKS),
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_PORTS-1:0]           i_req,
    input  logic [NUM_PORTS-1:0]           i_req_we,
    input  logic [NUM_PORTS*BANK_W-1:0]    i_req_bank,
    input  logic [NUM_PORTS*ADDR_W-1:0]    i_req_addr,
    input  logic [NUM_PORTS*WDATA_W-1:0]   i_req_wdata,
    output logic [NUM_PORTS-1:0]           o_gnt,
    output logic [NUM_PORTS-1:0]           o_rvalid,
    output logic [NUM_PORTS*RDATA_W-1:0]   o_rdata,
    output logic [NUM_BANKS-1:0]           o_bank_en,
    output logic [NUM_BANKS-1:0]           o_bank_we,
    output logic [NUM_BANKS*ADDR_W-1:0]    o_bank_addr,
    output logic [NUM_BANKS*WDATA_W-1:0]   o_bank_wdata,
    input  logic [NUM_BANKS*RDATA_W-1:0]   i_bank_rdata,
    output logic [CNT_W-1:0]               o_conflict_cnt,
    output logic                           o_oob_err
);

    // Round-robin pointers, one per bank
    logic [PORT_W-1:0] r_rr_ptr [NUM_BANKS];

    // Per-bank winner of the current cycle
    logic [NUM_BANKS-1:0] w_bank_act;
    logic [PORT_W-1:0]    w_win_id [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_rd_push;
    logic [NUM_PORTS-1:0] w_oob;
    logic                 w_conflict;

    // Tag pipeline: valid is control (reset), port id is payload (not reset)
    logic                 r_tag_vld [NUM_BANKS][READ_LAT];
    logic [PORT_W-1:0]    r_tag_id  [NUM_BANKS][READ_LAT];

    logic [CNT_W-1:0]     r_conflict_cnt;
    logic                 r_oob_err;

    function automatic logic [PORT_W-1:0] scan_idx(input logic [PORT_W-1:0] ptr, input int k);
        return PORT_W'((int'(ptr) + k) % NUM_PORTS);
    endfunction

    function automatic logic [PORT_W-1:0] ptr_next(input logic [PORT_W-1:0] id);
        return PORT_W'((int'(id) + 1) % NUM_PORTS);
    endfunction

    function automatic logic [BANK_W-1:0] bank_of(input logic [PORT_W-1:0] p);
        return i_req_bank[p*BANK_W +: BANK_W];
    endfunction

    // Counter that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Arbitration, grant generation and bank drive; everything idle during reset
    always_comb begin
        o_gnt        = '0;
        o_bank_en    = '0;
        o_bank_we    = '0;
        o_bank_addr  = '0;
        o_bank_wdata = '0;
        w_bank_act   = '0;
        w_rd_push    = '0;
        w_oob        = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_win_id[b] = '0;
        end
        if (!i_rst) begin
            // Out-of-range bank: accept and drop so the port never deadlocks
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (i_req[p] && (int'(bank_of(PORT_W'(p))) >= NUM_BANKS)) begin
                    w_oob[p] = 1'b1;
                    o_gnt[p] = 1'b1;
                end
            end
            // First requester at or after the pointer wins each bank
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (!w_bank_act[b] && i_req[scan_idx(r_rr_ptr[b], k)] &&
                        (bank_of(scan_idx(r_rr_ptr[b], k)) == BANK_W'(b))) begin
                        w_bank_act[b] = 1'b1;
                        w_win_id[b]   = scan_idx(r_rr_ptr[b], k);
                    end
                end
                if (w_bank_act[b]) begin
                    o_gnt[w_win_id[b]]                 = 1'b1;
                    o_bank_en[b]                       = 1'b1;
                    o_bank_we[b]                       = i_req_we[w_win_id[b]];
                    o_bank_addr[b*ADDR_W +: ADDR_W]    = i_req_addr[w_win_id[b]*ADDR_W +: ADDR_W];
                    o_bank_wdata[b*WDATA_W +: WDATA_W] = i_req_wdata[w_win_id[b]*WDATA_W +: WDATA_W];
                    w_rd_push[b]                       = ~i_req_we[w_win_id[b]];
                end
            end
        end
    end

    assign w_conflict = |(i_req & ~o_gnt);

    // Advance a bank's pointer past the port it just served
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NUM_BANKS; b++) r_rr_ptr[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_act[b]) r_rr_ptr[b] <= ptr_next(w_win_id[b]);
            end
        end
    end

    // Tag valid shift: stage 0 takes this cycle's granted read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int s = 0; s < READ_LAT; s++) r_tag_vld[b][s] <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_tag_vld[b][0] <= w_rd_push[b];
                for (int s = 1; s < READ_LAT; s++) r_tag_vld[b][s] <= r_tag_vld[b][s-1];
            end
        end
    end

    // Tag port-id shift, travelling alongside the valid bits
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            r_tag_id[b][0] <= w_win_id[b];
            for (int s = 1; s < READ_LAT; s++) r_tag_id[b][s] <= r_tag_id[b][s-1];
        end
    end

    // Steer exiting bank data to its owner; unreturned ports read as zero
    always_comb begin
        o_rvalid = '0;
        o_rdata  = '0;
        if (!i_rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_tag_vld[b][READ_LAT-1]) begin
                    o_rvalid[r_tag_id[b][READ_LAT-1]] = 1'b1;
                    o_rdata[r_tag_id[b][READ_LAT-1]*RDATA_W +: RDATA_W] =
                        i_bank_rdata[b*RDATA_W +: RDATA_W];
                end
            end
        end
    end

    // Count cycles in which at least one requester was left waiting
    always_ff @(posedge i_clk) begin
        if (i_rst)           r_conflict_cnt <= '0;
        else if (w_conflict) r_conflict_cnt <= sat_inc(r_conflict_cnt);
    end

    // Sticky flag for any out-of-range bank request
    always_ff @(posedge i_clk) begin
        if (i_rst)      r_oob_err <= 1'b0;
        else if (|w_oob) r_oob_err <= 1'b1;
    end

    assign o_conflict_cnt = r_conflict_cnt;
    assign o_oob_err      = r_oob_err;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Bench for sram_bank_arbiter: instance A (8 banks, READ_LAT=1, 32-bit counter)
// and instance B (6 banks, READ_LAT=3, 4-bit counter) with behavioural SRAM
// models. Expected read returns go into per-instance queues that monitors drain.
module tb_sram_bank_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A signals ----------------
    logic [3:0]     req_a, we_a, gnt_a, rvalid_a;
    logic [11:0]    bank_sel_a;
    logic [63:0]    addr_a;
    logic [31:0]    wdata_a;
    logic [127:0]   rdata_a;
    logic [7:0]     bank_en_a, bank_we_a;
    logic [127:0]   bank_addr_a;
    logic [63:0]    bank_wdata_a;
    logic [255:0]   bank_rdata_a;
    logic [31:0]    conflict_a;
    logic           oob_a;

    // ---------------- instance B signals ----------------
    logic [3:0]     req_b, we_b, gnt_b, rvalid_b;
    logic [11:0]    bank_sel_b;
    logic [63:0]    addr_b;
    logic [31:0]    wdata_b;
    logic [127:0]   rdata_b;
    logic [5:0]     bank_en_b, bank_we_b;
    logic [95:0]    bank_addr_b;
    logic [47:0]    bank_wdata_b;
    logic [191:0]   bank_rdata_b;
    logic [3:0]     conflict_b;
    logic           oob_b;

    sram_bank_arbiter #(.NUM_PORTS(4), .NUM_BANKS(8), .ADDR_W(16), .WDATA_W(8),
                        .RDATA_W(32), .READ_LAT(1), .CNT_W(32)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_req_we(we_a),
        .i_req_bank(bank_sel_a), .i_req_addr(addr_a), .i_req_wdata(wdata_a),
        .o_gnt(gnt_a), .o_rvalid(rvalid_a), .o_rdata(rdata_a),
        .o_bank_en(bank_en_a), .o_bank_we(bank_we_a), .o_bank_addr(bank_addr_a),
        .o_bank_wdata(bank_wdata_a), .i_bank_rdata(bank_rdata_a),
        .o_conflict_cnt(conflict_a), .o_oob_err(oob_a));

    sram_bank_arbiter #(.NUM_PORTS(4), .NUM_BANKS(6), .ADDR_W(16), .WDATA_W(8),
                        .RDATA_W(32), .READ_LAT(3), .CNT_W(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_req_we(we_b),
        .i_req_bank(bank_sel_b), .i_req_addr(addr_b), .i_req_wdata(wdata_b),
        .o_gnt(gnt_b), .o_rvalid(rvalid_b), .o_rdata(rdata_b),
        .o_bank_en(bank_en_b), .o_bank_we(bank_we_b), .o_bank_addr(bank_addr_b),
        .o_bank_wdata(bank_wdata_b), .i_bank_rdata(bank_rdata_b),
        .o_conflict_cnt(conflict_b), .o_oob_err(oob_b));

    // SRAM models: word = {bank, addr} until written; writes store zero-extended data
    logic [31:0] mem_a [8][16];
    logic [31:0] rp_a  [8];
    logic [31:0] mem_b [6][16];
    logic [31:0] rp_b  [6][3];

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (rst) begin
                for (int a = 0; a < 16; a++) mem_a[b][a] <= 32'((b << 16) | a);
            end else if (bank_en_a[b] && bank_we_a[b]) begin
                mem_a[b][bank_addr_a[b*16 +: 4]] <= {24'h0, bank_wdata_a[b*8 +: 8]};
            end
            rp_a[b] <= (bank_en_a[b] && !bank_we_a[b]) ? mem_a[b][bank_addr_a[b*16 +: 4]] : 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 6; b++) begin
            if (rst) begin
                for (int a = 0; a < 16; a++) mem_b[b][a] <= 32'((b << 16) | a);
            end else if (bank_en_b[b] && bank_we_b[b]) begin
                mem_b[b][bank_addr_b[b*16 +: 4]] <= {24'h0, bank_wdata_b[b*8 +: 8]};
            end
            rp_b[b][0] <= (bank_en_b[b] && !bank_we_b[b]) ? mem_b[b][bank_addr_b[b*16 +: 4]] : 32'h0;
            rp_b[b][1] <= rp_b[b][0];
            rp_b[b][2] <= rp_b[b][1];
        end
    end

    always_comb begin
        bank_rdata_a = '0;
        bank_rdata_b = '0;
        for (int b = 0; b < 8; b++) bank_rdata_a[b*32 +: 32] = rp_a[b];
        for (int b = 0; b < 6; b++) bank_rdata_b[b*32 +: 32] = rp_b[b][2];
    end

    // Monitor A: every rvalid must match the oldest outstanding entry for that port
    int idx_a;
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            n_vec++;
            if (rvalid_a[p]) begin
                idx_a = -1;
                for (int i = 0; i < qa.size(); i++) if (idx_a < 0 && qa[i].port == p) idx_a = i;
                if (idx_a < 0) begin
                    n_err++;
                    $display("FAIL rvalid_a[%0d] unexpected at cycle %0d: data %0h, required none", p, cyc, rdata_a[p*32 +: 32]);
                end else begin
                    if (rdata_a[p*32 +: 32] !== qa[idx_a].data || cyc != qa[idx_a].due) begin
                        n_err++;
                        $display("FAIL rdata_a[%0d]: got %0h at cycle %0d, required %0h at cycle %0d",
                                 p, rdata_a[p*32 +: 32], cyc, qa[idx_a].data, qa[idx_a].due);
                    end
                    qa.delete(idx_a);
                end
            end else if (rdata_a[p*32 +: 32] !== 32'h0) begin
                n_err++;
                $display("FAIL rdata_a[%0d] idle: got %0h, required 0", p, rdata_a[p*32 +: 32]);
            end
        end
    end

    // Monitor B
    int idx_b;
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            n_vec++;
            if (rvalid_b[p]) begin
                idx_b = -1;
                for (int i = 0; i < qb.size(); i++) if (idx_b < 0 && qb[i].port == p) idx_b = i;
                if (idx_b < 0) begin
                    n_err++;
                    $display("FAIL rvalid_b[%0d] unexpected at cycle %0d: data %0h, required none", p, cyc, rdata_b[p*32 +: 32]);
                end else begin
                    if (rdata_b[p*32 +: 32] !== qb[idx_b].data || cyc != qb[idx_b].due) begin
                        n_err++;
                        $display("FAIL rdata_b[%0d]: got %0h at cycle %0d, required %0h at cycle %0d",
                                 p, rdata_b[p*32 +: 32], cyc, qb[idx_b].data, qb[idx_b].due);
                    end
                    qb.delete(idx_b);
                end
            end else if (rdata_b[p*32 +: 32] !== 32'h0) begin
                n_err++;
                $display("FAIL rdata_b[%0d] idle: got %0h, required 0", p, rdata_b[p*32 +: 32]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req_a = '0; we_a = '0; bank_sel_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; bank_sel_b = '0; addr_b = '0; wdata_b = '0;
    endtask

    task automatic set_a(input int p, input logic we, input logic [2:0] bank,
                         input logic [15:0] addr, input logic [7:0] wd);
        req_a[p] = 1'b1; we_a[p] = we;
        bank_sel_a[p*3 +: 3] = bank; addr_a[p*16 +: 16] = addr; wdata_a[p*8 +: 8] = wd;
    endtask

    task automatic set_b(input int p, input logic we, input logic [2:0] bank,
                         input logic [15:0] addr, input logic [7:0] wd);
        req_b[p] = 1'b1; we_b[p] = we;
        bank_sel_b[p*3 +: 3] = bank; addr_b[p*16 +: 16] = addr; wdata_b[p*8 +: 8] = wd;
    endtask

    task automatic push_a(input int p, input logic [31:0] d, input int due);
        exp_t e;
        e.port = p; e.data = d; e.due = due;
        qa.push_back(e);
    endtask

    task automatic push_b(input int p, input logic [31:0] d, input int due);
        exp_t e;
        e.port = p; e.data = d; e.due = due;
        qb.push_back(e);
    endtask

    initial begin
        clear_all();
        rst = 1'b1;
        // Requests during reset must see no grant and no bank access
        set_a(0, 1'b0, 3'd0, 16'd0, 8'h0);
        set_a(1, 1'b0, 3'd1, 16'd0, 8'h0);
        set_b(0, 1'b0, 3'd0, 16'd0, 8'h0);
        @(negedge clk);
        chk("gnt_a in reset", 64'(gnt_a), 64'h0);
        chk("bank_en_a in reset", 64'(bank_en_a), 64'h0);
        chk("gnt_b in reset", 64'(gnt_b), 64'h0);
        chk("bank_en_b in reset", 64'(bank_en_b), 64'h0);
        chk("rvalid_a in reset", 64'(rvalid_a), 64'h0);
        chk("conflict_a after reset", 64'(conflict_a), 64'h0);
        chk("oob_a after reset", 64'(oob_a), 64'h0);
        chk("conflict_b after reset", 64'(conflict_b), 64'h0);
        tick();
        rst = 1'b0;
        clear_all();

        // Two ports, two banks, same cycle
        set_a(0, 1'b0, 3'd1, 16'd5, 8'h0);
        set_a(2, 1'b0, 3'd3, 16'd9, 8'h0);
        @(negedge clk);
        chk("t1 gnt_a", 64'(gnt_a), 64'h5);
        chk("t1 bank_en_a", 64'(bank_en_a), 64'h0A);
        chk("t1 bank1 addr", 64'(bank_addr_a[16 +: 16]), 64'd5);
        chk("t1 bank3 addr", 64'(bank_addr_a[48 +: 16]), 64'd9);
        push_a(0, 32'h0001_0005, cyc + 1);
        push_a(2, 32'h0003_0009, cyc + 1);
        tick();
        clear_all();
        @(negedge clk);
        chk("t1 conflict_a", 64'(conflict_a), 64'h0);
        tick();

        // Four ports hammer bank 2: strict rotation 0,1,2,3,...
        for (int p = 0; p < 4; p++) set_a(p, 1'b0, 3'd2, 16'(4 + p), 8'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2 gnt_a k=%0d", k), 64'(gnt_a), 64'(1 << (k % 4)));
            chk($sformatf("t2 conflict_a k=%0d", k), 64'(conflict_a), 64'(k));
            push_a(k % 4, 32'h0002_0004 + 32'(k % 4), cyc + 1);
            tick();
        end
        clear_all();
        @(negedge clk);
        chk("t2 conflict_a final", 64'(conflict_a), 64'd8);
        tick();

        // Write then read back through another port
        set_a(1, 1'b1, 3'd0, 16'd3, 8'h5A);
        @(negedge clk);
        chk("t3 gnt_a write", 64'(gnt_a), 64'h2);
        chk("t3 bank_en_a", 64'(bank_en_a), 64'h1);
        chk("t3 bank_we_a", 64'(bank_we_a), 64'h1);
        chk("t3 bank_wdata_a", 64'(bank_wdata_a[7:0]), 64'h5A);
        chk("t3 bank_addr_a", 64'(bank_addr_a[15:0]), 64'd3);
        tick();
        clear_all();
        set_a(3, 1'b0, 3'd0, 16'd3, 8'h0);
        @(negedge clk);
        chk("t3 gnt_a read", 64'(gnt_a), 64'h8);
        chk("t3 bank_we_a read", 64'(bank_we_a), 64'h0);
        push_a(3, 32'h0000_005A, cyc + 1);
        tick();
        clear_all();
        @(negedge clk);
        chk("t3 conflict_a", 64'(conflict_a), 64'd8);
        tick();

        // Reset right after granted reads: no return, pointers restart
        set_a(0, 1'b0, 3'd4, 16'd1, 8'h0);
        set_a(1, 1'b0, 3'd2, 16'd6, 8'h0);
        @(negedge clk);
        chk("t5 gnt_a before rst", 64'(gnt_a), 64'h3);
        tick();
        clear_all();
        rst = 1'b1;
        set_a(0, 1'b0, 3'd4, 16'd1, 8'h0);
        @(negedge clk);
        chk("t5 gnt_a in rst", 64'(gnt_a), 64'h0);
        chk("t5 bank_en_a in rst", 64'(bank_en_a), 64'h0);
        chk("t5 rvalid_a in rst", 64'(rvalid_a), 64'h0);
        chk("t5 rdata_a in rst", 64'(rdata_a[63:0]), 64'h0);
        tick();
        rst = 1'b0;
        clear_all();
        set_a(1, 1'b0, 3'd2, 16'd6, 8'h0);
        set_a(2, 1'b0, 3'd2, 16'd7, 8'h0);
        @(negedge clk);
        chk("t5 conflict_a cleared", 64'(conflict_a), 64'h0);
        chk("t5 oob_a cleared", 64'(oob_a), 64'h0);
        chk("t5 gnt_a rr restart", 64'(gnt_a), 64'h2);
        push_a(1, 32'h0002_0006, cyc + 1);
        tick();
        req_a[1] = 1'b0;
        @(negedge clk);
        chk("t5 gnt_a next", 64'(gnt_a), 64'h4);
        chk("t5 conflict_a", 64'(conflict_a), 64'h1);
        push_a(2, 32'h0002_0007, cyc + 1);
        tick();
        clear_all();

        // READ_LAT=3: back-to-back reads from p0 to banks 0,1,2
        for (int k = 0; k < 3; k++) begin
            clear_all();
            set_b(0, 1'b0, 3'(k), 16'(k + 1), 8'h0);
            @(negedge clk);
            chk($sformatf("t4 gnt_b k=%0d", k), 64'(gnt_b), 64'h1);
            push_b(0, 32'((k << 16) | (k + 1)), cyc + 3);
            tick();
        end
        clear_all();

        // Out-of-range bank on a 6-bank build
        set_b(2, 1'b0, 3'd7, 16'd0, 8'h0);
        @(negedge clk);
        chk("t6 gnt_b oob", 64'(gnt_b), 64'h4);
        chk("t6 bank_en_b oob", 64'(bank_en_b), 64'h0);
        chk("t6 oob_b not yet", 64'(oob_b), 64'h0);
        tick();
        clear_all();
        @(negedge clk);
        chk("t6 oob_b set", 64'(oob_b), 64'h1);
        tick();
        @(negedge clk);
        chk("t6 oob_b sticky", 64'(oob_b), 64'h1);
        chk("t6 conflict_b zero", 64'(conflict_b), 64'h0);
        tick();

        // Two ports fight for bank 5 long enough to saturate the 4-bit counter
        set_b(0, 1'b0, 3'd5, 16'd1, 8'h0);
        set_b(1, 1'b0, 3'd5, 16'd2, 8'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("t6 gnt_b k=%0d", k), 64'(gnt_b), (k % 2) ? 64'h2 : 64'h1);
            chk($sformatf("t6 conflict_b k=%0d", k), 64'(conflict_b), (k > 15) ? 64'd15 : 64'(k));
            push_b(k % 2, 32'h0005_0001 + 32'(k % 2), cyc + 3);
            tick();
        end
        clear_all();
        @(negedge clk);
        chk("t6 conflict_b saturated", 64'(conflict_b), 64'd15);
        chk("t6 oob_b still set", 64'(oob_b), 64'h1);

        // Drain outstanding returns
        for (int k = 0; k < 6; k++) tick();
        @(negedge clk);
        chk("qa drained", 64'(qa.size()), 64'h0);
        chk("qb drained", 64'(qb.size()), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("oob_b cleared by rst", 64'(oob_b), 64'h0);
        chk("conflict_b cleared by rst", 64'(conflict_b), 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
